yas_pkt_ctrl: RTL and testbench

// - Ingress packet controller for the router; sits between the input handshake and the three channel FIFOs.
// - Parses each packet header and resolves the destination against the ch0/1/2 addresses from the config registers.
// - Steers header and payload into exactly one channel FIFO, applying backpressure from FIFO full.
// - When crc_en=1, checks a trailing CRC-8 byte and reports per-packet completion or error.

---
 rtl/yas_pkg.sv | 36 +++
 rtl/yas_crc8.sv | 31 +++
 rtl/yas_pkt_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_yas_pkt_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yas_pkg.sv
// Shared definitions for the ingress packet controller: FSM encoding,
// header field layout, CRC polynomial and error codes.
package yas_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned NUM_CH     = 3;

    // Header layout: [7:2] payload length, [1:0] destination address
    localparam int unsigned LEN_MSB  = 7;
    localparam int unsigned LEN_LSB  = 2;
    localparam int unsigned ADDR_MSB = 1;
    localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned ADDR_W   = ADDR_MSB + 1;

    // Counter holds LEN plus an optional trailing CRC byte in DROP
    localparam int unsigned CNT_W = LEN_W + 1;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam logic [1:0] ERR_NO_ROUTE = 2'b01;
    localparam logic [1:0] ERR_CRC      = 2'b10;
    localparam logic [1:0] ERR_LEN      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

endpackage

// File: rtl/yas_crc8.sv
// Combinational CRC-8 step: folds one byte into the running CRC
// (poly 0x07, MSB first, no reflection).
// Ports:
//   i_crc  - current CRC value
//   i_byte - byte to fold in
//   o_crc  - CRC after the byte
module yas_crc8
    import yas_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] w_acc;

    // Byte-wise form: xor the byte in, then eight conditional shifts
    always_comb begin
        w_acc = i_crc ^ i_byte;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[7]) begin
                w_acc = (w_acc << 1) ^ CRC8_POLY;
            end else begin
                w_acc = w_acc << 1;
            end
        end
    end

    assign o_crc = w_acc;

endmodule

// File: rtl/yas_pkt_ctrl.sv
// Ingress packet controller: parses the header, routes the packet to one
// of three channel FIFOs, applies FIFO backpressure, optionally checks a
// trailing CRC-8 byte and pulses completion/error per packet.
// Ports:
//   clk, rst              - clock, async active-high reset
//   data_in/_req/_ack     - input byte handshake (ack combinational)
//   ch0/1/2_addr, crc_en  - configuration
//   fifo_full             - per-channel FIFO full
//   fifo_wr, fifo_wdata   - per-channel write strobe (combinational), data
//   pkt_done, pkt_err,
//   err_code              - registered end-of-packet status
//   busy                  - FSM not in IDLE
module yas_pkt_ctrl
    import yas_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = yas_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_req,
    output logic                  data_in_ack,
    input  logic [1:0]            ch0_addr,
    input  logic [1:0]            ch1_addr,
    input  logic [1:0]            ch2_addr,
    input  logic                  crc_en,
    input  logic [NUM_CH-1:0]     fifo_full,
    output logic [NUM_CH-1:0]     fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic [1:0]            err_code,
    output logic                  busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [7:0]       r_crc;
    logic [7:0]       w_crc_nxt;
    logic             r_crc_en;
    logic             w_crc_en_nxt;
    logic             r_pkt_done;
    logic             w_pkt_done_nxt;
    logic             r_pkt_err;
    logic             w_pkt_err_nxt;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_code_nxt;

    hdr_t             w_hdr;
    logic [7:0]       w_byte;
    logic             w_len_zero;
    logic [1:0]       w_route_sel;
    logic             w_route_ok;
    logic [1:0]       w_sel_cur;
    logic             w_fwd;
    logic             w_ack;
    logic             w_xfer;
    logic [7:0]       w_crc_in;
    logic [7:0]       w_crc_calc;

    assign w_byte     = data_in[LEN_MSB:0];
    assign w_hdr      = hdr_t'(w_byte);
    assign w_len_zero = (w_hdr.len == '0);

    // Destination lookup, lowest-index channel wins on duplicate addresses
    always_comb begin
        w_route_ok  = 1'b1;
        w_route_sel = 2'd0;
        if (w_hdr.addr == ch0_addr) begin
            w_route_sel = 2'd0;
        end else if (w_hdr.addr == ch1_addr) begin
            w_route_sel = 2'd1;
        end else if (w_hdr.addr == ch2_addr) begin
            w_route_sel = 2'd2;
        end else begin
            w_route_ok = 1'b0;
        end
    end

    // A header always starts from a zero CRC
    assign w_crc_in = (r_state == ST_IDLE) ? 8'h00 : r_crc;

    yas_crc8 u_crc8 (
        .i_crc  (w_crc_in),
        .i_byte (w_byte),
        .o_crc  (w_crc_calc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sel      <= 2'd0;
            r_crc      <= 8'h00;
            r_crc_en   <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_crc      <= w_crc_nxt;
            r_crc_en   <= w_crc_en_nxt;
            r_pkt_done <= w_pkt_done_nxt;
            r_pkt_err  <= w_pkt_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Next-state and datapath register update
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_sel_nxt      = r_sel;
        w_crc_nxt      = r_crc;
        w_crc_en_nxt   = r_crc_en;
        w_pkt_done_nxt = 1'b0;
        w_pkt_err_nxt  = 1'b0;
        w_err_code_nxt = 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_crc_nxt    = w_crc_calc;
                    w_crc_en_nxt = crc_en;
                    if (w_len_zero) begin
                        w_pkt_err_nxt  = 1'b1;
                        w_err_code_nxt = ERR_LEN;
                    end else if (!w_route_ok) begin
                        // Drop count includes the trailing CRC byte
                        w_cnt_nxt   = CNT_W'(w_hdr.len) + CNT_W'(crc_en);
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_sel_nxt   = w_route_sel;
                        w_cnt_nxt   = CNT_W'(w_hdr.len);
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (w_xfer) begin
                    w_crc_nxt = w_crc_calc;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_crc_en) begin
                            w_state_nxt = ST_CRC;
                        end else begin
                            w_state_nxt    = ST_IDLE;
                            w_pkt_done_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_CRC: begin
                if (w_xfer) begin
                    w_state_nxt = ST_IDLE;
                    if (w_byte == r_crc) begin
                        w_pkt_done_nxt = 1'b1;
                    end else begin
                        w_pkt_err_nxt  = 1'b1;
                        w_err_code_nxt = ERR_CRC;
                    end
                end
            end

            ST_DROP: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt    = ST_IDLE;
                        w_pkt_err_nxt  = 1'b1;
                        w_err_code_nxt = ERR_NO_ROUTE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake and FIFO strobe; only routed header/payload bytes are forwarded
    always_comb begin
        w_ack     = 1'b0;
        w_fwd     = 1'b0;
        w_sel_cur = r_sel;

        case (r_state)
            ST_IDLE: begin
                w_sel_cur = w_route_sel;
                if (w_len_zero || !w_route_ok) begin
                    w_ack = data_in_req;
                end else begin
                    w_fwd = 1'b1;
                    w_ack = data_in_req && !fifo_full[w_route_sel];
                end
            end
            ST_PAYLOAD: begin
                w_fwd = 1'b1;
                w_ack = data_in_req && !fifo_full[r_sel];
            end
            ST_CRC, ST_DROP: begin
                w_ack = data_in_req;
            end
            default: begin
                w_ack = 1'b0;
            end
        endcase

        if (rst) begin
            w_ack = 1'b0;
        end
    end

    assign w_xfer      = w_ack;
    assign data_in_ack = w_ack;
    assign fifo_wr     = (w_fwd && w_xfer) ? (NUM_CH'(1) << w_sel_cur) : '0;
    assign fifo_wdata  = data_in;
    assign pkt_done    = r_pkt_done;
    assign pkt_err     = r_pkt_err;
    assign err_code    = r_err_code;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_yas_pkt_ctrl.sv
// Bench for yas_pkt_ctrl: a byte-stream packet parser model checks the
// DUT every cycle; directed packets pin exact counts and CRC values.
module tb_yas_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_req;
    logic       data_in_ack;
    logic [1:0] ch0_addr, ch1_addr, ch2_addr;
    logic       crc_en;
    logic [2:0] fifo_full;
    logic [2:0] fifo_wr;
    logic [7:0] fifo_wdata;
    logic       pkt_done, pkt_err, busy;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    // Stimulus-side full control
    logic       rand_full = 1'b0;
    logic [2:0] full_force = 3'b000;

    // Monitor counters (written only by the compare process)
    int wr_cnt [3];
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [1:0] last_code = 2'b00;

    // Snapshots (written only by the main process)
    int b_wr [3];
    int b_done, b_err;

    always #5 clk = ~clk;

    yas_pkt_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_in_req (data_in_req),
        .data_in_ack (data_in_ack),
        .ch0_addr    (ch0_addr),
        .ch1_addr    (ch1_addr),
        .ch2_addr    (ch2_addr),
        .crc_en      (crc_en),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_wdata  (fifo_wdata),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit-serial polynomial division over the whole message
    function automatic logic [7:0] crc8_ref(input logic [7:0] q[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    function automatic int route(input logic [1:0] a);
        if (a == ch0_addr) return 0;
        if (a == ch1_addr) return 1;
        if (a == ch2_addr) return 2;
        return -1;
    endfunction

    // FIFO-full driver, settles after the data driver each cycle
    initial begin
        fifo_full = 3'b000;
        forever begin
            @(posedge clk);
            #2;
            if (rand_full) begin
                for (int i = 0; i < 3; i++) fifo_full[i] = ($urandom_range(0, 3) == 0);
            end else begin
                fifo_full = full_force;
            end
        end
    end

    // Reference model: parses the accepted byte stream packet by packet
    bit         m_active = 0, m_fwd = 0, m_crcen = 0;
    int         m_ch = 0, m_rem = 0;
    logic [7:0] m_bytes[$];
    bit         m_pd = 0, m_pe = 0;
    logic [1:0] m_code = 2'b00;

    always @(negedge clk) begin
        int         r;
        int         len;
        logic       exp_ack;
        logic [2:0] exp_wr;
        if (rst) begin
            chk("rst_ack", 32'(data_in_ack), 32'(0));
            chk("rst_wr", 32'(fifo_wr), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(pkt_done), 32'(0));
            chk("rst_err", 32'(pkt_err), 32'(0));
            chk("rst_code", 32'(err_code), 32'(0));
            m_active = 0; m_pd = 0; m_pe = 0; m_rem = 0;
        end else begin
            chk("pkt_done", 32'(pkt_done), 32'(m_pd));
            chk("pkt_err", 32'(pkt_err), 32'(m_pe));
            if (m_pe) chk("err_code", 32'(err_code), 32'(m_code));
            chk("busy", 32'(busy), 32'(m_active));
            if (pkt_done) done_cnt++;
            if (pkt_err) begin err_cnt++; last_code = err_code; end
            for (int i = 0; i < 3; i++) if (fifo_wr[i]) wr_cnt[i]++;

            len = int'(data_in[7:2]);
            r   = route(data_in[1:0]);
            exp_ack = 1'b0;
            exp_wr  = 3'b000;
            if (data_in_req) begin
                if (!m_active) begin
                    if (len == 0 || r < 0) exp_ack = 1'b1;
                    else begin
                        exp_ack = !fifo_full[r];
                        if (exp_ack) exp_wr = 3'(1 << r);
                    end
                end else if (m_fwd && m_rem > 0) begin
                    exp_ack = !fifo_full[m_ch];
                    if (exp_ack) exp_wr = 3'(1 << m_ch);
                end else begin
                    exp_ack = 1'b1;
                end
            end
            chk("ack", 32'(data_in_ack), 32'(exp_ack));
            chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
            if (exp_wr != 3'b000) chk("wdata", 32'(fifo_wdata), 32'(data_in));

            m_pd = 0; m_pe = 0;
            if (data_in_req && data_in_ack) begin
                if (!m_active) begin
                    if (len == 0) begin
                        m_pe = 1; m_code = 2'b11;
                    end else if (r < 0) begin
                        m_active = 1; m_fwd = 0; m_rem = len + (crc_en ? 1 : 0);
                    end else begin
                        m_active = 1; m_fwd = 1; m_ch = r; m_rem = len;
                        m_crcen = crc_en; m_bytes = {data_in};
                    end
                end else if (m_fwd && m_rem > 0) begin
                    m_bytes.push_back(data_in);
                    m_rem--;
                    if (m_rem == 0 && !m_crcen) begin m_active = 0; m_pd = 1; end
                end else if (m_fwd) begin
                    m_active = 0;
                    if (data_in == crc8_ref(m_bytes)) m_pd = 1;
                    else begin m_pe = 1; m_code = 2'b10; end
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin m_active = 0; m_pe = 1; m_code = 2'b01; end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        data_in     = b;
        data_in_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_in_ack && n < 300);
        if (!data_in_ack) begin
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, n);
        end
        @(posedge clk);
        #1;
        data_in_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_in_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) b_wr[i] = wr_cnt[i];
        b_done = done_cnt;
        b_err  = err_cnt;
    endtask

    task automatic set_cfg(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2,
                           input logic ce);
        ch0_addr = a0; ch1_addr = a1; ch2_addr = a2; crc_en = ce;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] tq[$];
        int         len;
        bit         abort;

        for (int i = 0; i < 3; i++) begin wr_cnt[i] = 0; b_wr[i] = 0; end
        rst = 1'b1;
        data_in = 8'h00;
        data_in_req = 1'b0;
        set_cfg(2'd0, 2'd1, 2'd2, 1'b0);

        // Model pins
        tq = {8'h04};
        chk("crc_ref_04", 32'(crc8_ref(tq)), 32'h1C);
        tq = {8'h04, 8'h00};
        chk("crc_ref_0400", 32'(crc8_ref(tq)), 32'h54);

        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(pkt_done), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Routed packet to ch1, no CRC
        snap();
        send_byte(8'h09); send_byte(8'hAA); send_byte(8'hBB);
        idle(2);
        chk("d1_wr1", 32'(wr_cnt[1] - b_wr[1]), 32'(3));
        chk("d1_done", 32'(done_cnt - b_done), 32'(1));

        // CRC good, then CRC bad
        crc_en = 1'b1;
        snap();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h54);
        idle(2);
        chk("d2_wr0", 32'(wr_cnt[0] - b_wr[0]), 32'(2));
        chk("d2_done", 32'(done_cnt - b_done), 32'(1));
        snap();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h55);
        idle(2);
        chk("d2_err", 32'(err_cnt - b_err), 32'(1));
        chk("d2_code", 32'(last_code), 32'(2));

        // Backpressure during payload
        crc_en = 1'b0;
        snap();
        send_byte(8'h09);
        full_force  = 3'b010;
        data_in     = 8'hAA;
        data_in_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("hold_ack", 32'(data_in_ack), 32'(0));
            chk("hold_busy", 32'(busy), 32'(1));
            chk("hold_wr", 32'(fifo_wr), 32'(0));
        end
        @(posedge clk);
        #1;
        full_force = 3'b000;
        send_byte(8'hAA); send_byte(8'hBB);
        idle(2);
        chk("d3_wr1", 32'(wr_cnt[1] - b_wr[1]), 32'(3));
        chk("d3_done", 32'(done_cnt - b_done), 32'(1));

        // No route: dropped
        set_cfg(2'd0, 2'd0, 2'd0, 1'b0);
        snap();
        send_byte(8'h07); send_byte(8'h11);
        idle(2);
        chk("d4_wr", 32'((wr_cnt[0] + wr_cnt[1] + wr_cnt[2]) - (b_wr[0] + b_wr[1] + b_wr[2])), 32'(0));
        chk("d4_err", 32'(err_cnt - b_err), 32'(1));
        chk("d4_code", 32'(last_code), 32'(1));

        // Zero length, then reset mid-packet
        set_cfg(2'd0, 2'd1, 2'd2, 1'b0);
        snap();
        send_byte(8'h01);
        idle(2);
        chk("d5_err", 32'(err_cnt - b_err), 32'(1));
        chk("d5_code", 32'(last_code), 32'(3));
        chk("d5_wr1", 32'(wr_cnt[1] - b_wr[1]), 32'(0));
        snap();
        send_byte(8'h09); send_byte(8'hAA);
        rst = 1'b1;
        data_in = 8'hBB;
        data_in_req = 1'b1;
        @(negedge clk);
        chk("d5_rst_busy", 32'(busy), 32'(0));
        chk("d5_rst_ack", 32'(data_in_ack), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_in_req = 1'b0;
        idle(2);
        chk("d5_no_pulse", 32'((done_cnt - b_done) + (err_cnt - b_err)), 32'(0));
        snap();
        send_byte(8'h05); send_byte(8'hCC);
        idle(2);
        chk("d5_wr1_after", 32'(wr_cnt[1] - b_wr[1]), 32'(2));
        chk("d5_done_after", 32'(done_cnt - b_done), 32'(1));

        // Randomized traffic with random backpressure, config changes and resets
        rand_full = 1'b1;
        for (int p = 0; p < 300; p++) begin
            if ($urandom_range(0, 3) == 0)
                set_cfg(2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            q = {{6'(len), 2'($urandom)}};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            if (crc_en && len > 0)
                q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : crc8_ref(q));
            abort = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < q.size(); i++) begin
                if (abort && i == q.size() / 2 && i > 0) begin
                    do_reset();
                    break;
                end
                send_byte(q[i]);
                if ($urandom_range(0, 15) == 0) begin
                    ch0_addr = 2'($urandom); ch1_addr = 2'($urandom); ch2_addr = 2'($urandom);
                end
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_full = 1'b0;
        idle(3);
        chk("end_busy", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
